// File: rtl/main_module_1.sv
// Two-register 8-bit datapath executing one 4-bit command per clock edge.
// All operands come from the pre-edge register values; arithmetic wraps modulo 256.
module main_module_1 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] in,
  input  logic [3:0] command,
  output logic [7:0] R1_out,
  output logic [7:0] R2_out
);

  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_LDR1 = 4'd1,
    CMD_LDR2 = 4'd2,
    CMD_ADD  = 4'd3,
    CMD_SUB  = 4'd4,
    CMD_AND  = 4'd5,
    CMD_OR   = 4'd6,
    CMD_XOR  = 4'd7,
    CMD_NOT  = 4'd8,
    CMD_SHL  = 4'd9,
    CMD_SHR  = 4'd10,
    CMD_SWAP = 4'd11,
    CMD_MOV  = 4'd12,
    CMD_INC  = 4'd13,
    CMD_DEC  = 4'd14,
    CMD_CLR  = 4'd15
  } cmd_t;

  logic [7:0] r1_reg, r1_next;
  logic [7:0] r2_reg, r2_next;
  cmd_t       cmd;

  assign cmd = cmd_t'(command);

  always_comb begin
    r1_next = r1_reg;
    r2_next = r2_reg;
    unique case (cmd)
      CMD_NOP:  ;
      CMD_LDR1: r1_next = in;
      CMD_LDR2: r2_next = in;
      CMD_ADD:  r1_next = r1_reg + r2_reg;
      CMD_SUB:  r1_next = r1_reg - r2_reg;
      CMD_AND:  r1_next = r1_reg & r2_reg;
      CMD_OR:   r1_next = r1_reg | r2_reg;
      CMD_XOR:  r1_next = r1_reg ^ r2_reg;
      CMD_NOT:  r1_next = ~r1_reg;
      CMD_SHL:  r1_next = {r1_reg[6:0], 1'b0};
      CMD_SHR:  r1_next = {1'b0, r1_reg[7:1]};
      // Both sides read the old values, so the exchange is race-free.
      CMD_SWAP: begin
        r1_next = r2_reg;
        r2_next = r1_reg;
      end
      CMD_MOV:  r2_next = r1_reg;
      CMD_INC:  r1_next = r1_reg + 8'd1;
      CMD_DEC:  r1_next = r1_reg - 8'd1;
      CMD_CLR:  begin
        r1_next = 8'h00;
        r2_next = 8'h00;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r1_reg <= 8'h00;
      r2_reg <= 8'h00;
    end else begin
      r1_reg <= r1_next;
      r2_reg <= r2_next;
    end
  end

  assign R1_out = r1_reg;
  assign R2_out = r2_reg;

endmodule

// File: tb/tb_main_module_1.sv
// Directed bench for main_module_1: a vector table applied one edge per record,
// followed by hand-written sequences for held commands and reset priority.
module tb_main_module_1;

  logic       clock;
  logic       resetn;
  logic [7:0] in;
  logic [3:0] command;
  logic [7:0] R1_out;
  logic [7:0] R2_out;

  int n_compared;
  int n_mismatched;

  main_module_1 dut (
    .clock   (clock),
    .resetn  (resetn),
    .in      (in),
    .command (command),
    .R1_out  (R1_out),
    .R2_out  (R2_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rstn;
    logic [3:0] cmd;
    logic [7:0] din;
    logic [7:0] exp_r1;
    logic [7:0] exp_r2;
  } vec_t;

  vec_t vecs [0:33];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
    end
  endtask

  // Drive on the falling edge, let one rising edge execute, sample 1 ns later.
  task automatic step(input logic rstn, input logic [3:0] cmd, input logic [7:0] din,
                      input logic [7:0] exp_r1, input logic [7:0] exp_r2, input string tag);
    @(negedge clock);
    resetn  = rstn;
    command = cmd;
    in      = din;
    @(posedge clock);
    #1;
    $display("%s: rstn=%0b cmd=%0d in=%02h -> R1=%02h R2=%02h", tag, rstn, cmd, din, R1_out, R2_out);
    check({tag, ".R1"}, R1_out, exp_r1);
    check({tag, ".R2"}, R2_out, exp_r2);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn  = 1'b0;
    command = 4'd0;
    in      = 8'h00;

    vecs[0]  = '{1'b0, 4'd0,  8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 4'd1,  8'hFF, 8'hFF, 8'h00};
    vecs[2]  = '{1'b1, 4'd2,  8'h01, 8'hFF, 8'h01};
    vecs[3]  = '{1'b1, 4'd3,  8'h55, 8'h00, 8'h01};
    vecs[4]  = '{1'b1, 4'd4,  8'h00, 8'hFF, 8'h01};
    vecs[5]  = '{1'b1, 4'd1,  8'hA5, 8'hA5, 8'h01};
    vecs[6]  = '{1'b1, 4'd2,  8'h0F, 8'hA5, 8'h0F};
    vecs[7]  = '{1'b1, 4'd5,  8'hFF, 8'h05, 8'h0F};
    vecs[8]  = '{1'b1, 4'd1,  8'hA5, 8'hA5, 8'h0F};
    vecs[9]  = '{1'b1, 4'd7,  8'h00, 8'hAA, 8'h0F};
    vecs[10] = '{1'b1, 4'd9,  8'h00, 8'h54, 8'h0F};
    vecs[11] = '{1'b1, 4'd10, 8'h00, 8'h2A, 8'h0F};
    vecs[12] = '{1'b1, 4'd8,  8'h00, 8'hD5, 8'h0F};
    vecs[13] = '{1'b1, 4'd6,  8'h00, 8'hDF, 8'h0F};
    vecs[14] = '{1'b1, 4'd1,  8'h12, 8'h12, 8'h0F};
    vecs[15] = '{1'b1, 4'd2,  8'h34, 8'h12, 8'h34};
    vecs[16] = '{1'b1, 4'd11, 8'hEE, 8'h34, 8'h12};
    vecs[17] = '{1'b1, 4'd12, 8'hEE, 8'h34, 8'h34};
    vecs[18] = '{1'b1, 4'd15, 8'h00, 8'h00, 8'h00};
    vecs[19] = '{1'b1, 4'd14, 8'h00, 8'hFF, 8'h00};
    vecs[20] = '{1'b1, 4'd13, 8'h00, 8'h00, 8'h00};
    vecs[21] = '{1'b1, 4'd13, 8'h00, 8'h01, 8'h00};
    vecs[22] = '{1'b1, 4'd0,  8'hFF, 8'h01, 8'h00};
    vecs[23] = '{1'b1, 4'd1,  8'h77, 8'h77, 8'h00};
    vecs[24] = '{1'b0, 4'd13, 8'h00, 8'h00, 8'h00};
    vecs[25] = '{1'b1, 4'd13, 8'h00, 8'h01, 8'h00};
    vecs[26] = '{1'b1, 4'd2,  8'h80, 8'h01, 8'h80};
    vecs[27] = '{1'b1, 4'd4,  8'h00, 8'h81, 8'h80};
    vecs[28] = '{1'b1, 4'd9,  8'h00, 8'h02, 8'h80};
    vecs[29] = '{1'b1, 4'd3,  8'h00, 8'h82, 8'h80};
    vecs[30] = '{1'b1, 4'd12, 8'h00, 8'h82, 8'h82};
    vecs[31] = '{1'b1, 4'd15, 8'hFF, 8'h00, 8'h00};
    vecs[32] = '{1'b1, 4'd1,  8'h5A, 8'h5A, 8'h00};
    vecs[33] = '{1'b1, 4'd2,  8'hC3, 8'h5A, 8'hC3};

    for (int i = 0; i <= 33; i++) begin
      step(vecs[i].rstn, vecs[i].cmd, vecs[i].din, vecs[i].exp_r1, vecs[i].exp_r2,
           $sformatf("vec%0d", i));
    end

    // Reset beats SWAP issued on the same edge.
    step(1'b0, 4'd11, 8'hFF, 8'h00, 8'h00, "rst_vs_swap");

    // INC held for three edges across the 0xFF wrap.
    step(1'b1, 4'd1, 8'hFE, 8'hFE, 8'h00, "inc_setup");
    step(1'b1, 4'd13, 8'h00, 8'hFF, 8'h00, "inc_hold0");
    step(1'b1, 4'd13, 8'h11, 8'h00, 8'h00, "inc_hold1");
    step(1'b1, 4'd13, 8'h22, 8'h01, 8'h00, "inc_hold2");

    // NOP for five edges with in toggling: nothing may move.
    step(1'b1, 4'd2, 8'h3C, 8'h01, 8'h3C, "nop_setup");
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'd0, 8'(k * 8'h37), 8'h01, 8'h3C, $sformatf("nop%0d", k));
    end

    // DEC held for two edges across the 0x00 wrap, then SHR on a value with bit 0 set.
    step(1'b1, 4'd14, 8'h00, 8'h00, 8'h3C, "dec_hold0");
    step(1'b1, 4'd14, 8'h00, 8'hFF, 8'h3C, "dec_hold1");
    step(1'b1, 4'd10, 8'h00, 8'h7F, 8'h3C, "shr_msb0");

    // Reset held for two edges, then execution resumes on the first high edge.
    step(1'b0, 4'd1, 8'h99, 8'h00, 8'h00, "rst_hold0");
    step(1'b0, 4'd2, 8'h99, 8'h00, 8'h00, "rst_hold1");
    step(1'b1, 4'd14, 8'h00, 8'hFF, 8'h00, "resume_dec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
